// File: rtl/pipe_pkg.sv
// Shared pipeline constants for the write-back stage and register file.
// Configuration macro WB_REGFILE_BYPASS_EN (see regfile_2r1w) enables write-first read bypass.
package pipe_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int REG_ZERO = 0;

    // Encoding matches the polarity of the MemtoReg control bit.
    typedef enum logic {
        WB_SEL_ALU = 1'b0,
        WB_SEL_MEM = 1'b1
    } wb_sel_e;

endpackage : pipe_pkg

// File: rtl/regfile_2r1w.sv
// Architectural register file: two asynchronous read ports, one write port, $0 hardwired to zero.
// Macro WB_REGFILE_BYPASS_EN: when defined, reads of the register being written return the new value.
module regfile_2r1w #(
    parameter int DATA_W = pipe_pkg::DATA_W,
    parameter int ADDR_W = pipe_pkg::ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr_a,
    input  logic [ADDR_W-1:0] i_raddr_b,
    output logic [DATA_W-1:0] o_rdata_a,
    output logic [DATA_W-1:0] o_rdata_b
);
    import pipe_pkg::*;

    localparam int NREGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] regs [NREGS];
    logic              wr_valid;

    assign wr_valid = i_we && (i_waddr != ZERO_IDX);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            // NOTE: the whole array is reset because software relies on every register reading 0
            // after reset; this keeps it in flops rather than a RAM macro, which is fine at 32x32.
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_valid) begin
            // NOTE: non-blocking so the read ports see the pre-edge value until the edge completes.
            regs[i_waddr] <= i_wdata;
        end
    end

    always_comb begin
        // NOTE: both outputs get a default first so no path through this block can infer a latch.
        o_rdata_a = '0;
        o_rdata_b = '0;
        if (i_raddr_a != ZERO_IDX) begin
            o_rdata_a = regs[i_raddr_a];
        end
        if (i_raddr_b != ZERO_IDX) begin
            o_rdata_b = regs[i_raddr_b];
        end
`ifdef WB_REGFILE_BYPASS_EN
        // Write-first: the value being committed this cycle wins over the stored copy.
        if (wr_valid && (i_raddr_a == i_waddr)) begin
            o_rdata_a = i_wdata;
        end
        if (wr_valid && (i_raddr_b == i_waddr)) begin
            o_rdata_b = i_wdata;
        end
`else
        // Stored value only; the hazard unit stalls ID for one cycle on a same-index read.
`endif
    end

endmodule : regfile_2r1w

// File: rtl/wb_regfile.sv
// Write-back stage: selects load data vs ALU result, commits it to the register file,
// drives the forwarding bus and counts retired writes. Bypass option: WB_REGFILE_BYPASS_EN.
module wb_regfile #(
    parameter int DATA_W = pipe_pkg::DATA_W,
    parameter int ADDR_W = pipe_pkg::ADDR_W,
    parameter int CNT_W  = 32
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_MemtoReg,
    input  logic              i_RegWrite,
    input  logic [DATA_W-1:0] i_Rdata,
    input  logic [DATA_W-1:0] i_ALUresult,
    input  logic [ADDR_W-1:0] i_Reg_Dst,
    input  logic [ADDR_W-1:0] i_Rs_addr,
    input  logic [ADDR_W-1:0] i_Rt_addr,
    output logic [DATA_W-1:0] o_Rs_data,
    output logic [DATA_W-1:0] o_Rt_data,
    output logic [DATA_W-1:0] o_WB_data,
    output logic              o_WB_en,
    output logic [ADDR_W-1:0] o_WB_Reg_Dst,
    output logic [CNT_W-1:0]  o_wb_count
);
    import pipe_pkg::*;

    wb_sel_e wb_sel;

    assign wb_sel       = wb_sel_e'(i_MemtoReg);
    assign o_WB_data    = (wb_sel == WB_SEL_MEM) ? i_Rdata : i_ALUresult;
    assign o_WB_Reg_Dst = i_Reg_Dst;
    // Writes to $0 are dropped here so they neither commit nor count.
    assign o_WB_en      = i_RegWrite && (i_Reg_Dst != ADDR_W'(REG_ZERO));

    regfile_2r1w #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_regfile (
        .i_clk     (i_clk),
        .i_rstn    (i_rstn),
        .i_we      (o_WB_en),
        .i_waddr   (i_Reg_Dst),
        .i_wdata   (o_WB_data),
        .i_raddr_a (i_Rs_addr),
        .i_raddr_b (i_Rt_addr),
        .o_rdata_a (o_Rs_data),
        .o_rdata_b (o_Rt_data)
    );

    // Retired-write counter, wraps naturally at 2**CNT_W.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_wb_count <= '0;
        end else if (o_WB_en) begin
            o_wb_count <= o_wb_count + CNT_W'(1);
        end
    end

endmodule : wb_regfile

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios plus randomized traffic against an array model.
module tb_wb_regfile;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 4;

    logic          i_clk = 1'b0;
    logic          i_rstn;
    logic          i_MemtoReg;
    logic          i_RegWrite;
    logic [DW-1:0] i_Rdata;
    logic [DW-1:0] i_ALUresult;
    logic [AW-1:0] i_Reg_Dst;
    logic [AW-1:0] i_Rs_addr;
    logic [AW-1:0] i_Rt_addr;
    logic [DW-1:0] o_Rs_data;
    logic [DW-1:0] o_Rt_data;
    logic [DW-1:0] o_WB_data;
    logic          o_WB_en;
    logic [AW-1:0] o_WB_Reg_Dst;
    logic [CW-1:0] o_wb_count;

    int checks   = 0;
    int failures = 0;

    // Reference model: architectural register contents and retired-write count.
    logic [DW-1:0] mdl [32];
    int            mcnt;

    always #5 i_clk = ~i_clk;

    wb_regfile #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .CNT_W  (CW)
    ) dut (
        .i_clk        (i_clk),
        .i_rstn       (i_rstn),
        .i_MemtoReg   (i_MemtoReg),
        .i_RegWrite   (i_RegWrite),
        .i_Rdata      (i_Rdata),
        .i_ALUresult  (i_ALUresult),
        .i_Reg_Dst    (i_Reg_Dst),
        .i_Rs_addr    (i_Rs_addr),
        .i_Rt_addr    (i_Rt_addr),
        .o_Rs_data    (o_Rs_data),
        .o_Rt_data    (o_Rt_data),
        .o_WB_data    (o_WB_data),
        .o_WB_en      (o_WB_en),
        .o_WB_Reg_Dst (o_WB_Reg_Dst),
        .o_wb_count   (o_wb_count)
    );

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] model_read(input int idx, input bit en, input int dst,
                                                 input logic [DW-1:0] wb);
        if (idx == 0) return '0;
`ifdef WB_REGFILE_BYPASS_EN
        if (en && idx == dst) return wb;
`endif
        return mdl[idx];
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) mdl[i] = '0;
        mcnt = 0;
    endfunction

    // One pipeline cycle: drive at negedge, check combinational outputs, commit at posedge, check after.
    task automatic do_cycle(input bit we, input bit m2r, input logic [DW-1:0] rdata,
                            input logic [DW-1:0] alu, input int dst, input int rs, input int rt);
        logic [DW-1:0] exp_wb;
        bit            exp_en;
        @(negedge i_clk);
        i_RegWrite  = we;
        i_MemtoReg  = m2r;
        i_Rdata     = rdata;
        i_ALUresult = alu;
        i_Reg_Dst   = AW'(dst);
        i_Rs_addr   = AW'(rs);
        i_Rt_addr   = AW'(rt);
        #1;
        exp_wb = m2r ? rdata : alu;
        exp_en = we && (dst != 0);
        check("wb_data", o_WB_data, exp_wb);
        check("wb_en", {31'b0, o_WB_en}, {31'b0, exp_en});
        check("wb_dst", {27'b0, o_WB_Reg_Dst}, DW'(dst));
        check("rs_pre", o_Rs_data, model_read(rs, exp_en, dst, exp_wb));
        check("rt_pre", o_Rt_data, model_read(rt, exp_en, dst, exp_wb));
        @(posedge i_clk);
        #1;
        if (exp_en) begin
            mdl[dst] = exp_wb;
            mcnt     = (mcnt + 1) % (1 << CW);
        end
        check("count", {28'b0, o_wb_count}, DW'(mcnt));
    endtask

    // Idle cycle that only reads two indices after the previous edge has settled.
    task automatic read_pair(input int rs, input int rt, input string tag);
        do_cycle(1'b0, 1'b0, '0, '0, 0, rs, rt);
        check(tag, o_Rs_data, (rs == 0) ? '0 : mdl[rs]);
    endtask

    initial begin
        i_rstn      = 1'b0;
        i_RegWrite  = 1'b0;
        i_MemtoReg  = 1'b0;
        i_Rdata     = '0;
        i_ALUresult = '0;
        i_Reg_Dst   = '0;
        i_Rs_addr   = '0;
        i_Rt_addr   = '0;
        model_reset();

        // Reset: every index reads 0 and the counter is 0.
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        i_rstn = 1'b1;
        for (int i = 0; i < 32; i++) begin
            do_cycle(1'b0, 1'b0, '0, '0, 0, i, 31 - i);
            check("reset_rs", o_Rs_data, '0);
            check("reset_rt", o_Rt_data, '0);
        end
        check("reset_count", {28'b0, o_wb_count}, '0);

        // ALU write then load write to reg5.
        do_cycle(1'b1, 1'b0, 32'h0, 32'h0000_1234, 5, 0, 0);
        read_pair(5, 5, "alu_write");
        check("alu_value", o_Rs_data, 32'h0000_1234);
        check("alu_count", {28'b0, o_wb_count}, 32'd1);
        do_cycle(1'b1, 1'b1, 32'hDEAD_BEEF, 32'h5555_5555, 5, 0, 0);
        read_pair(5, 0, "mem_write");
        check("mem_value", o_Rs_data, 32'hDEAD_BEEF);
        check("mem_count", {28'b0, o_wb_count}, 32'd2);

        // $0 protection: request ignored, not counted.
        do_cycle(1'b1, 1'b0, 32'h0, 32'hFFFF_FFFF, 0, 0, 0);
        check("zero_en", {31'b0, o_WB_en}, '0);
        check("zero_read", o_Rs_data, '0);
        check("zero_count", {28'b0, o_wb_count}, 32'd2);

        // Same-cycle write/read hazard on reg7.
        do_cycle(1'b1, 1'b0, 32'h0, 32'h0000_0011, 7, 0, 0);
        do_cycle(1'b1, 1'b0, 32'h0, 32'h0000_0022, 7, 7, 7);
        read_pair(7, 7, "hazard_after");
        check("hazard_value", o_Rt_data, 32'h0000_0022);

        // Asynchronous reset between edges, no clock edge required.
        do_cycle(1'b1, 1'b0, 32'h0, 32'hA5A5_A5A5, 31, 31, 31);
        check("r31_written", o_Rs_data, 32'hA5A5_A5A5);
        i_RegWrite = 1'b0;
        #2;
        i_rstn = 1'b0;
        #1;
        model_reset();
        check("async_rs", o_Rs_data, '0);
        check("async_count", {28'b0, o_wb_count}, '0);
        @(negedge i_clk);
        i_rstn = 1'b1;

        // Counter wrap: 16 valid writes return to 0, an idle cycle leaves it there.
        for (int i = 0; i < 16; i++) begin
            do_cycle(1'b1, i[0], 32'h100 + i, 32'h200 + i, 1 + (i % 31), 0, 1);
        end
        check("wrap_count", {28'b0, o_wb_count}, '0);
        do_cycle(1'b0, 1'b0, 32'h0, 32'h0, 3, 1, 2);
        check("idle_count", {28'b0, o_wb_count}, '0);

        // Randomized traffic; a quarter of targets hit $0, reads often alias the destination.
        for (int n = 0; n < 300; n++) begin
            int dst;
            int rs;
            int rt;
            dst = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 31));
            rs  = ($urandom_range(0, 2) == 0) ? dst : int'($urandom_range(0, 31));
            rt  = ($urandom_range(0, 2) == 0) ? dst : int'($urandom_range(0, 31));
            do_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
                     dst, rs, rt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_wb_regfile
